// File: rtl/dma_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_bus_arbiter_if : CPU / DMA-channel / RAM-port bundle for the arbiter.  |
// | Optional: DMA_BYTE_OP_EN adds per-channel dma_byte_op.  Rev 1.0            |
// +----------------------------------------------------------------------------+
interface dma_bus_arbiter_if #(
   parameter int NCHAN = 2,
   parameter int AW    = 22,
   parameter int DW    = 16
);
   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   logic                bus_arbitrate;
   logic [AW-1:0]       bus_addr;
   logic [DW-1:0]       bus_data_in;
   logic                bus_rd;
   logic                bus_wr;
   logic                bus_byte_op;
   logic                bus_ack;
   logic [NCHAN-1:0]    dma_req;
   logic [NCHAN-1:0]    dma_ack;
   logic [NCHAN*AW-1:0] dma_addr;
   logic [NCHAN*DW-1:0] dma_data_out;
   logic [NCHAN-1:0]    dma_rd;
   logic [NCHAN-1:0]    dma_wr;
`ifdef DMA_BYTE_OP_EN
   logic [NCHAN-1:0]    dma_byte_op;
`endif
   logic [CW-1:0]       dma_owner;
   logic [AW-1:0]       ram_addr;
   logic [DW-1:0]       ram_data_out;
   logic                ram_rd;
   logic                ram_wr;
   logic                ram_byte_op;

   modport master (
`ifdef DMA_BYTE_OP_EN
      input  dma_byte_op,
`endif
      input  bus_arbitrate, bus_addr, bus_data_in, bus_rd, bus_wr, bus_byte_op,
      input  dma_req, dma_addr, dma_data_out, dma_rd, dma_wr,
      output bus_ack, dma_ack, dma_owner,
      output ram_addr, ram_data_out, ram_rd, ram_wr, ram_byte_op
   );

   modport slave (
`ifdef DMA_BYTE_OP_EN
      output dma_byte_op,
`endif
      output bus_arbitrate, bus_addr, bus_data_in, bus_rd, bus_wr, bus_byte_op,
      output dma_req, dma_addr, dma_data_out, dma_rd, dma_wr,
      input  bus_ack, dma_ack, dma_owner,
      input  ram_addr, ram_data_out, ram_rd, ram_wr, ram_byte_op
   );
endinterface

`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_bus_arbiter : round-robin burst arbiter of RAM between CPU and NCHAN   |
// | DMA channels. Optional: DMA_BYTE_OP_EN (byte strobes from DMA). Rev 1.0    |
// +----------------------------------------------------------------------------+
module dma_bus_arbiter #(
   parameter int NCHAN = 2,
   parameter int BURST = 4,
   parameter int AW    = 22,
   parameter int DW    = 16
) (
   input  wire logic         clk,
   input  wire logic         reset,
   dma_bus_arbiter_if.master bus
);
   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   typedef enum logic [0:0] {
      ST_CPU = 1'b0,
      ST_DMA = 1'b1
   } state_t;

   state_t           st_q;
   logic [CW-1:0]    owner_q;
   logic [CW-1:0]    last_q;
   logic [CW-1:0]    owner_d;
   logic [3:0]       cnt_q;
   logic             bus_ack_q;
   logic [NCHAN-1:0] dma_ack_q;

   // Round-robin pick: descending scan so the nearest channel after last_q wins.
   always_comb begin
      int idx;
      idx     = 0;
      owner_d = last_q;
      for (int i = NCHAN; i >= 1; i--) begin
         idx = (int'(last_q) + i) % NCHAN;
         if (bus.dma_req[idx]) begin
            owner_d = CW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q      <= ST_CPU;
         owner_q   <= '0;
         last_q    <= CW'(NCHAN - 1);
         cnt_q     <= 4'd0;
         bus_ack_q <= 1'b1;
         dma_ack_q <= '0;
      end else begin
         case (st_q)
            ST_CPU: begin
               if (bus.bus_arbitrate && (|bus.dma_req)) begin
                  st_q      <= ST_DMA;
                  owner_q   <= owner_d;
                  cnt_q     <= 4'd1;
                  bus_ack_q <= 1'b0;
                  dma_ack_q <= NCHAN'(1) << owner_d;
               end
            end
            ST_DMA: begin
               // Always hand back to the CPU for a cycle, even with others pending.
               if ((cnt_q == 4'(BURST)) || !bus.dma_req[owner_q]) begin
                  st_q      <= ST_CPU;
                  last_q    <= owner_q;
                  bus_ack_q <= 1'b1;
                  dma_ack_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               st_q      <= ST_CPU;
               bus_ack_q <= 1'b1;
               dma_ack_q <= '0;
            end
         endcase
      end
   end

   assign bus.bus_ack   = bus_ack_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.dma_owner = owner_q;

   always_comb begin
      int sel;
      sel              = int'(owner_q);
      bus.ram_addr     = bus.bus_addr;
      bus.ram_data_out = bus.bus_data_in;
      bus.ram_rd       = bus.bus_rd;
      bus.ram_wr       = bus.bus_wr;
      bus.ram_byte_op  = bus.bus_byte_op;
      if (st_q == ST_DMA) begin
         bus.ram_addr     = bus.dma_addr[sel*AW +: AW];
         bus.ram_data_out = bus.dma_data_out[sel*DW +: DW];
         bus.ram_rd       = bus.dma_rd[owner_q];
         bus.ram_wr       = bus.dma_wr[owner_q];
`ifdef DMA_BYTE_OP_EN
         bus.ram_byte_op  = bus.dma_byte_op[owner_q];
`else
         bus.ram_byte_op  = 1'b0;
`endif
      end
   end
endmodule

`default_nettype wire
